qerv_dbus_ctrl: RTL and testbench

// Data-bus controller that sits between the data buffer register and the Wishbone data port.
// - Issues one Wishbone load/store per memory instruction:
//   - the store word comes already byte-positioned from the buffer register;
//   - the load word goes back into the buffer register through a load strobe.
// - While the loaded word is shifted out BITS_PER_CYCLE bits per cycle, produces the byte-valid qualifier.
// - Sign/zero-extends the rd result.

---
 rtl/qerv_dbus_ctrl_if.sv | 15 +
 rtl/qerv_dbus_ctrl.sv | 161 ++++++++++++++++
 tb/tb_qerv_dbus_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qerv_dbus_ctrl_if.sv
// Wishbone data-port bundle between the data-bus controller (master) and memory (slave).
interface qerv_dbus_ctrl_if;
    // Handshake: master raises cyc (also acting as stb) with adr/dat/sel/we held stable;
    // slave answers with a one-cycle ack (rdt valid with it on reads); master drops cyc next cycle.
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/qerv_dbus_ctrl.sv
// Data-bus controller: one Wishbone load/store per memory instruction, plus the
// byte-valid qualifier and sign/zero extension applied while the load word is shifted out.
module qerv_dbus_ctrl #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int TIMEOUT        = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    qerv_dbus_ctrl_if.master          io_wb,
    input  logic                      i_req,
    input  logic                      i_we,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic [1:0]                i_lsb,
    input  logic [31:0]               i_adr,
    input  logic [31:0]               i_sdat,
    output logic                      o_load,
    output logic [31:0]               o_ldat,
    output logic                      o_done,
    output logic                      o_misalign,
    output logic                      o_err,
    input  logic                      i_rd_en,
    input  logic [4:0]                i_cnt,
    input  logic [BITS_PER_CYCLE-1:0] i_q,
    output logic                      o_byte_valid,
    output logic [BITS_PER_CYCLE-1:0] o_rd,
    output logic [1:0]                o_dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, FIN = 2'd2} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          r_state, w_nxt_state;
    logic [31:0]     r_adr, r_dat, r_ldat;
    logic [3:0]      r_sel, w_sel;
    logic            r_we, r_cyc, r_done, r_load, r_mis, r_err, r_sign;
    logic [CW-1:0]   r_tcnt;
    logic            w_nxt_cyc, w_nxt_done, w_nxt_load, w_nxt_mis, w_nxt_err;
    logic            w_accept, w_misaligned, w_timeout, w_word, w_half, w_byte_valid;
    logic            w_unused;

    assign w_word       = i_size[1];
    assign w_half       = (i_size == 2'b01);
    assign w_misaligned = (w_half & i_lsb[0]) | (w_word & (i_lsb != 2'b00));
    assign w_timeout    = (TIMEOUT > 0) && (r_tcnt == TO_LAST);
    assign w_unused     = &{1'b0, i_adr[1:0]};

    always_comb begin
        w_sel = 4'b1111;
        case (i_size)
            2'b00:   w_sel = 4'b0001 << i_lsb;
            2'b01:   w_sel = i_lsb[1] ? 4'b1100 : 4'b0011;
            default: w_sel = 4'b1111;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cyc   <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cyc   <= w_nxt_cyc;
            r_done  <= w_nxt_done;
            r_load  <= w_nxt_load;
            r_mis   <= w_nxt_mis;
            r_err   <= w_nxt_err;
        end
    end

    // A request seen in the o_done cycle belongs to the op just finishing, so it is not accepted.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cyc   = r_cyc;
        w_nxt_done  = 1'b0;
        w_nxt_load  = 1'b0;
        w_nxt_mis   = 1'b0;
        w_nxt_err   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && !r_done) begin
                    if (w_misaligned) begin
                        w_nxt_mis  = 1'b1;
                        w_nxt_done = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_nxt_cyc   = 1'b1;
                        w_nxt_state = BUS;
                    end
                end
            end
            BUS: begin
                if (io_wb.ack) begin
                    w_nxt_cyc   = 1'b0;
                    w_nxt_done  = 1'b1;
                    w_nxt_load  = !r_we;
                    w_nxt_state = FIN;
                end else if (w_timeout) begin
                    w_nxt_cyc   = 1'b0;
                    w_nxt_err   = 1'b1;
                    w_nxt_done  = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            FIN: w_nxt_state = IDLE;
            default: begin
                w_nxt_cyc   = 1'b0;
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_adr  <= 32'd0;
            r_dat  <= 32'd0;
            r_sel  <= 4'd0;
            r_we   <= 1'b0;
            r_ldat <= 32'd0;
            r_tcnt <= '0;
            r_sign <= 1'b0;
        end else begin
            if (w_accept) begin
                r_adr  <= {i_adr[31:2], 2'b00};
                r_dat  <= i_sdat;
                r_sel  <= w_sel;
                r_we   <= i_we;
                r_tcnt <= '0;
            end else if (r_state == BUS) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (r_state == BUS && io_wb.ack && !r_we)
                r_ldat <= io_wb.rdt;
            if (i_rd_en && w_byte_valid)
                r_sign <= i_q[BITS_PER_CYCLE-1];
        end
    end

    // Chunks past the accessed size are replaced by the last valid MSB (or zero).
    assign w_byte_valid = w_word | (i_cnt[4:3] == 2'b00) | (w_half & !i_cnt[4]);
    assign o_byte_valid = w_byte_valid;
    assign o_rd         = w_byte_valid ? i_q : {BITS_PER_CYCLE{i_signed & r_sign}};

    assign io_wb.adr   = r_adr;
    assign io_wb.dat   = r_dat;
    assign io_wb.sel   = r_sel;
    assign io_wb.we    = r_we;
    assign io_wb.cyc   = r_cyc;
    assign o_load      = r_load;
    assign o_ldat      = r_ldat;
    assign o_done      = r_done;
    assign o_misalign  = r_mis;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_qerv_dbus_ctrl.sv
// Self-checking bench for qerv_dbus_ctrl: directed scenarios plus randomized ops
// compared against a size/alignment model of the Wishbone transaction and extension rules.
module tb_qerv_dbus_ctrl;
  localparam int B  = 1;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sgn, rd_en;
  logic [1:0]  size, lsb, dbg_state;
  logic [31:0] adr, sdat, ldat;
  logic        load, done, mis, err, byte_valid;
  logic [4:0]  cnt;
  logic [B-1:0] q, rd;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // observations recorded by run_op
  int          ob_cyc_len, ob_done_c, ob_done_n, ob_load_n, ob_err_n, ob_mis_n;
  logic [31:0] ob_adr, ob_dat, ob_ldat;
  logic [3:0]  ob_sel;
  logic        ob_we;
  bit          ob_stable;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  qerv_dbus_ctrl_if wb ();

  qerv_dbus_ctrl #(.BITS_PER_CYCLE(B), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .io_wb(wb),
    .i_req(req), .i_we(we), .i_size(size), .i_signed(sgn), .i_lsb(lsb),
    .i_adr(adr), .i_sdat(sdat),
    .o_load(load), .o_ldat(ldat), .o_done(done), .o_misalign(mis), .o_err(err),
    .i_rd_en(rd_en), .i_cnt(cnt), .i_q(q), .o_byte_valid(byte_valid), .o_rd(rd),
    .o_dbg_state(dbg_state)
  );

  // reference model: an access of N bytes is aligned iff lsb is a multiple of N
  function automatic int m_nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] s, input logic [1:0] l);
    return (int'(l) % m_nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] s, input logic [1:0] l);
    int lanes;
    lanes = ((1 << m_nbytes(s)) - 1) << int'(l);
    return lanes[3:0];
  endfunction

  // driver: issues one request, plays the Wishbone slave (ack after dly BUS cycles),
  // and records what the DUT did until one cycle past o_done
  task automatic run_op(input logic i_we, input logic [1:0] i_size, input logic [1:0] i_lsb,
                        input logic [31:0] i_adr, input logic [31:0] i_sdat,
                        input logic [31:0] i_rdt, input int dly, input bit hold);
    int bus_k;
    bus_k = 0;
    ob_cyc_len = 0; ob_done_c = -1; ob_done_n = 0; ob_load_n = 0; ob_err_n = 0; ob_mis_n = 0;
    ob_adr = '0; ob_dat = '0; ob_ldat = '0; ob_sel = '0; ob_we = 1'b0; ob_stable = 1'b1;
    req = 1'b1; we = i_we; size = i_size; lsb = i_lsb; adr = i_adr; sdat = i_sdat;
    wb.rdt = i_rdt; wb.ack = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wb.cyc) begin
        if (ob_cyc_len == 0) begin
          ob_adr = wb.adr; ob_dat = wb.dat; ob_sel = wb.sel; ob_we = wb.we;
        end else if (ob_adr !== wb.adr || ob_dat !== wb.dat || ob_sel !== wb.sel || ob_we !== wb.we) begin
          ob_stable = 1'b0;
        end
        ob_cyc_len++;
        wb.ack = (bus_k == dly);
        bus_k++;
      end else begin
        wb.ack = 1'b0;
      end
      if (done) begin
        ob_done_n++;
        if (ob_done_c < 0) ob_done_c = c;
        if (!hold) req = 1'b0;
      end
      if (load) begin ob_load_n++; ob_ldat = ldat; end
      if (err) ob_err_n++;
      if (mis) ob_mis_n++;
      if (ob_done_c >= 0 && c == ob_done_c + 1) break;
    end
    wb.ack = 1'b0;
    if (!hold) req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; lsb = 2'd0; adr = '0; sdat = '0;
    sgn = 1'b1; rd_en = 1'b0; cnt = 5'd8; q = '1; wb.rdt = '0; wb.ack = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({wb.cyc, done, load, err, mis, wb.we} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {wb.cyc, done, load, err, mis, wb.we});
    end
    total++; if ({wb.adr, wb.dat, wb.sel} !== 68'd0) begin
      bad++; $display("FAIL reset_bus got adr=%h dat=%h sel=%h exp=0", wb.adr, wb.dat, wb.sel);
    end
    total++; if (ldat !== 32'd0) begin bad++; $display("FAIL reset_ldat got=%h exp=0", ldat); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_bv got=%b exp=0", byte_valid); end
    total++; if (rd !== '0) begin bad++; $display("FAIL reset_sign_fill got=%b exp=0", rd); end
  endtask

  task automatic test_word_load();
    exp_q.push_back(32'hDEADBEEF);
    run_op(1'b0, 2'd2, 2'd0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
    total++; if (ob_sel !== 4'hF || ob_adr !== 32'h100 || ob_we !== 1'b0) begin
      bad++; $display("FAIL wl_bus got sel=%h adr=%h we=%b exp sel=f adr=100 we=0", ob_sel, ob_adr, ob_we);
    end
    total++; if (ob_cyc_len != 2) begin bad++; $display("FAIL wl_cyc_len got=%0d exp=2", ob_cyc_len); end
    total++; if (ob_done_c != 3 || ob_done_n != 1 || ob_load_n != 1) begin
      bad++; $display("FAIL wl_done got at=%0d n=%0d load=%0d exp at=3 n=1 load=1", ob_done_c, ob_done_n, ob_load_n);
    end
    total++; if (ob_ldat !== exp_q.pop_front()) begin bad++; $display("FAIL wl_ldat got=%h exp=deadbeef", ob_ldat); end
  endtask

  task automatic test_byte_store();
    run_op(1'b1, 2'd0, 2'd2, 32'h0000_0206, 32'h00AA_0000, 32'h5555_5555, 0, 1'b0);
    total++; if (ob_we !== 1'b1 || ob_sel !== 4'b0100 || ob_dat !== 32'h00AA0000 || ob_adr !== 32'h204) begin
      bad++; $display("FAIL bs_bus got we=%b sel=%b dat=%h adr=%h exp we=1 sel=0100 dat=00aa0000 adr=204",
                      ob_we, ob_sel, ob_dat, ob_adr);
    end
    total++; if (ob_done_c != 2 || ob_done_n != 1 || ob_load_n != 0 || ob_cyc_len != 1) begin
      bad++; $display("FAIL bs_done got at=%0d n=%0d load=%0d cyc=%0d exp at=2 n=1 load=0 cyc=1",
                      ob_done_c, ob_done_n, ob_load_n, ob_cyc_len);
    end
  endtask

  task automatic test_misalign();
    run_op(1'b0, 2'd1, 2'd1, 32'h0000_0301, 32'h0, 32'h0, 0, 1'b0);
    total++; if (ob_mis_n != 1 || ob_done_c != 1 || ob_done_n != 1 || ob_cyc_len != 0 || ob_load_n != 0) begin
      bad++; $display("FAIL mis_half got mis=%0d at=%0d done=%0d cyc=%0d load=%0d exp 1 1 1 0 0",
                      ob_mis_n, ob_done_c, ob_done_n, ob_cyc_len, ob_load_n);
    end
    run_op(1'b1, 2'd2, 2'd2, 32'h0000_0302, 32'h0, 32'h0, 0, 1'b0);
    total++; if (ob_mis_n != 1 || ob_done_c != 1 || ob_cyc_len != 0) begin
      bad++; $display("FAIL mis_word got mis=%0d at=%0d cyc=%0d exp 1 1 0", ob_mis_n, ob_done_c, ob_cyc_len);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 2'd2, 2'd0, 32'h0000_0400, 32'h0, 32'h1111_2222, 99, 1'b0);
    total++; if (ob_cyc_len != TO || ob_err_n != 1 || ob_done_n != 1 || ob_done_c != TO + 1 || ob_load_n != 0) begin
      bad++; $display("FAIL timeout got cyc=%0d err=%0d done=%0d at=%0d load=%0d exp %0d 1 1 %0d 0",
                      ob_cyc_len, ob_err_n, ob_done_n, ob_done_c, ob_load_n, TO, TO + 1);
    end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL timeout_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_back_to_back();
    // request stays high through o_done: nothing new in the done cycle, accepted the cycle after
    run_op(1'b0, 2'd1, 2'd3, 32'h0000_0503, 32'h0, 32'h0, 0, 1'b1);
    total++; if (ob_cyc_len != 0 || ob_done_n != 1) begin
      bad++; $display("FAIL b2b_mis got cyc=%0d done=%0d exp 0 1", ob_cyc_len, ob_done_n);
    end
    run_op(1'b0, 2'd0, 2'd3, 32'h0000_0607, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
    total++; if (ob_done_c != 2 || ob_cyc_len != 1 || ob_sel !== 4'b1000 || ob_ldat !== 32'hCAFEF00D) begin
      bad++; $display("FAIL b2b_load got at=%0d cyc=%0d sel=%b ldat=%h exp 2 1 1000 cafef00d",
                      ob_done_c, ob_cyc_len, ob_sel, ob_ldat);
    end
    run_op(1'b1, 2'd1, 2'd2, 32'h0000_070A, 32'hBEEF_0000, 32'h0, 2, 1'b0);
    total++; if (ob_done_c != 4 || ob_cyc_len != 3 || ob_sel !== 4'b1100 || !ob_stable) begin
      bad++; $display("FAIL b2b_store got at=%0d cyc=%0d sel=%b stable=%0d exp 4 3 1100 1",
                      ob_done_c, ob_cyc_len, ob_sel, ob_stable);
    end
  endtask

  task automatic test_bus_reset();
    int leftovers;
    req = 1'b1; we = 1'b0; size = 2'd2; lsb = 2'd0; adr = 32'h0000_0800; wb.rdt = 32'h0; wb.ack = 1'b0;
    @(negedge clk);
    total++; if (wb.cyc !== 1'b1) begin bad++; $display("FAIL rstbus_start got cyc=%b exp=1", wb.cyc); end
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    total++; if ({wb.cyc, done, load} !== 3'b000) begin
      bad++; $display("FAIL rstbus_drop got cyc/done/load=%b exp=000", {wb.cyc, done, load});
    end
    rst = 1'b0;
    leftovers = 0;
    repeat (3) begin
      @(negedge clk);
      if (wb.cyc || done || load) leftovers++;
    end
    total++; if (leftovers != 0) begin bad++; $display("FAIL rstbus_quiet got=%0d exp=0", leftovers); end
    run_op(1'b0, 2'd1, 2'd2, 32'h0000_0902, 32'h0, 32'h1234_ABCD, 0, 1'b0);
    total++; if (ob_done_c != 2 || ob_sel !== 4'b1100 || ob_load_n != 1 || ob_ldat !== 32'h1234ABCD) begin
      bad++; $display("FAIL rstbus_after got at=%0d sel=%b load=%0d ldat=%h exp 2 1100 1 1234abcd",
                      ob_done_c, ob_sel, ob_load_n, ob_ldat);
    end
  endtask

  task automatic test_serial();
    logic [31:0] val, mask, ext;
    logic [1:0]  s;
    logic        sg;
    int          nbits;
    for (int pass = 0; pass < 8; pass++) begin
      if (pass < 2) begin
        val = 32'h0000_0080; s = 2'd0; sg = (pass == 0);
      end else begin
        val = $urandom; s = 2'($urandom_range(0, 3)); sg = 1'($urandom_range(0, 1));
      end
      nbits = m_nbytes(s) * 8;
      mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
      ext   = val & mask;
      if (sg && val[nbits-1]) ext = ext | ~mask;
      size = s; sgn = sg; rd_en = 1'b1;
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        cnt = 5'(c); q = val[c];
        #1;
        total++; if (byte_valid !== (c < nbits)) begin
          bad++; $display("FAIL ser_bv pass=%0d cnt=%0d got=%b exp=%b", pass, c, byte_valid, (c < nbits));
        end
        total++; if (rd !== ext[c]) begin
          bad++; $display("FAIL ser_rd pass=%0d cnt=%0d got=%b exp=%b", pass, c, rd, ext[c]);
        end
      end
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_random();
    logic        r_we;
    logic [1:0]  r_size, r_lsb;
    logic [31:0] r_adr, r_sdat, r_rdt;
    int          dly, e_cyc, e_done_c;
    bit          e_mis, e_to;
    for (int n = 0; n < 40; n++) begin
      r_we = 1'($urandom_range(0, 1)); r_size = 2'($urandom_range(0, 3)); r_lsb = 2'($urandom_range(0, 3));
      r_adr = $urandom; r_adr[1:0] = r_lsb; r_sdat = $urandom; r_rdt = $urandom;
      dly = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3);
      e_mis = m_mis(r_size, r_lsb);
      e_to  = !e_mis && (dly >= TO);
      e_cyc = e_mis ? 0 : (e_to ? TO : dly + 1);
      e_done_c = e_mis ? 1 : (e_to ? TO + 1 : dly + 2);
      if (!e_mis && !e_to && !r_we) exp_q.push_back(r_rdt);
      run_op(r_we, r_size, r_lsb, r_adr, r_sdat, r_rdt, dly, 1'b0);
      total++; if (ob_cyc_len != e_cyc || ob_done_c != e_done_c || ob_done_n != 1) begin
        bad++; $display("FAIL rnd_timing op=%0d got cyc=%0d at=%0d n=%0d exp cyc=%0d at=%0d n=1",
                        n, ob_cyc_len, ob_done_c, ob_done_n, e_cyc, e_done_c);
      end
      total++; if (ob_mis_n != int'(e_mis) || ob_err_n != int'(e_to) ||
                   ob_load_n != int'(!e_mis && !e_to && !r_we)) begin
        bad++; $display("FAIL rnd_flags op=%0d got mis=%0d err=%0d load=%0d exp mis=%0d err=%0d we=%b",
                        n, ob_mis_n, ob_err_n, ob_load_n, e_mis, e_to, r_we);
      end
      if (!e_mis) begin
        total++; if (ob_adr !== {r_adr[31:2], 2'b00} || ob_sel !== m_sel(r_size, r_lsb) ||
                     ob_we !== r_we || !ob_stable || (r_we && ob_dat !== r_sdat)) begin
          bad++; $display("FAIL rnd_bus op=%0d got adr=%h sel=%b we=%b dat=%h stable=%0d exp adr=%h sel=%b we=%b dat=%h",
                          n, ob_adr, ob_sel, ob_we, ob_dat, ob_stable, {r_adr[31:2], 2'b00},
                          m_sel(r_size, r_lsb), r_we, r_sdat);
        end
        if (!e_to && !r_we) begin
          total++; if (ob_ldat !== exp_q.pop_front()) begin
            bad++; $display("FAIL rnd_ldat op=%0d got=%h exp=%h", n, ob_ldat, r_rdt);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_bus_reset();
    test_serial();
    test_random();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
